dds_phase_acc: RTL and testbench

- Direct digital synthesis phase accumulator.
- Sits directly upstream of the waveform ROM stage and drives its 8-bit phase input every clock.
- Frequency is set by a tuning word; updates are phase-continuous, applied either immediately or at the next phase wrap.
- Also outputs a cycle-start pulse for downstream framing and scope triggering.

---
 rtl/dds_phase_acc_if.sv | 42 ++++
 rtl/dds_phase_acc.sv | 172 +++++++++++++++++
 tb/tb_dds_phase_acc.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_phase_acc_if.sv
// dds_phase_acc_if: control/status bundle between a DDS controller and the
// phase accumulator. The master drives tuning/run controls and the slave
// (the accumulator) returns phase and framing strobes.
// Optional sweep signals exist only when PHASE_SWEEP_EN is defined.
interface dds_phase_acc_if #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8
);
  logic               en;
  logic [ACC_W-1:0]   freq_word;
  logic               freq_load;
  logic               upd_mode;
  logic [PHASE_W-1:0] phase_offset;
  logic [PHASE_W-1:0] phase_out;
  logic               phase_valid;
  logic               wrap;
  logic               load_ack;
`ifdef PHASE_SWEEP_EN
  logic               sweep_start;
  logic [ACC_W-1:0]   sweep_step;
  logic [ACC_W-1:0]   sweep_stop;
  logic               sweep_done;
`endif

  modport master (
    output en, freq_word, freq_load, upd_mode, phase_offset,
`ifdef PHASE_SWEEP_EN
    output sweep_start, sweep_step, sweep_stop,
    input  sweep_done,
`endif
    input  phase_out, phase_valid, wrap, load_ack
  );

  modport slave (
    input  en, freq_word, freq_load, upd_mode, phase_offset,
`ifdef PHASE_SWEEP_EN
    input  sweep_start, sweep_step, sweep_stop,
    output sweep_done,
`endif
    output phase_out, phase_valid, wrap, load_ack
  );
endinterface

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: DDS phase accumulator feeding the waveform ROM address.
// Tuning word updates are phase-continuous, applied either on the next add
// or deferred to the next accumulator wrap. The top PHASE_W bits of the
// accumulator plus a static offset form the registered phase output.
// Optional linear frequency sweep is compiled in with PHASE_SWEEP_EN.
// ACC_W must be >= 9 so the phase slice sits strictly below the carry.
module dds_phase_acc #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8
) (
  input logic            clk,
  input logic            rst,
  dds_phase_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PHASE_SWEEP_EN
    SWEEP = 2'd2,
`endif
    RUN   = 2'd1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_active;
  logic [ACC_W-1:0]   ftw_pend;
  logic               pend_flag;
  logic [PHASE_W-1:0] phase_q;
  logic               valid_q;
  logic               wrap_q;
  logic               ack_q;

  // One add per clock; the carry out marks the start of a new phase cycle.
  logic [ACC_W:0]     sum;
  logic               carry;
  logic [PHASE_W-1:0] phase_next;
  logic               pend_apply;

  assign sum        = {1'b0, acc} + {1'b0, ftw_active};
  assign carry      = sum[ACC_W];
  assign phase_next = sum[ACC_W-1 -: PHASE_W] + bus.phase_offset;
  // A zero FTW never wraps, so a deferred word must not wait for a carry.
  assign pend_apply = pend_flag && (carry || (ftw_active == '0));

`ifdef PHASE_SWEEP_EN
  logic               sweep_done_q;
  logic [ACC_W:0]     swp_sum;
  logic               swp_hit;

  // Next swept FTW; overflow or reaching the stop value ends the sweep.
  assign swp_sum = {1'b0, ftw_active} + {1'b0, bus.sweep_step};
  assign swp_hit = swp_sum[ACC_W] || (swp_sum[ACC_W-1:0] >= bus.sweep_stop);
  assign bus.sweep_done = sweep_done_q;
`endif

  assign bus.phase_out   = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.load_ack    = ack_q;

  // Control FSM, accumulator and tuning-word bookkeeping, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      ftw_active <= '0;
      ftw_pend   <= '0;
      pend_flag  <= 1'b0;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
`ifdef PHASE_SWEEP_EN
      sweep_done_q <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef PHASE_SWEEP_EN
      sweep_done_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          acc <= '0;
          if (bus.en) begin
            // First valid phase is the bare offset, flagged as a cycle start.
            state   <= RUN;
            phase_q <= bus.phase_offset;
            valid_q <= 1'b1;
            wrap_q  <= 1'b1;
          end else begin
            phase_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
          end
          // Nothing is running, so a load always takes effect at once.
          if (bus.freq_load) begin
            ftw_active <= bus.freq_word;
            pend_flag  <= 1'b0;
            ack_q      <= 1'b1;
          end
        end

        default: begin
          if (!bus.en) begin
            state   <= IDLE;
            acc     <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            // Leaving RUN must not strand a deferred word; newest load wins.
            if (bus.freq_load) begin
              ftw_active <= bus.freq_word;
              pend_flag  <= 1'b0;
              ack_q      <= 1'b1;
            end else if (pend_flag) begin
              ftw_active <= ftw_pend;
              pend_flag  <= 1'b0;
              ack_q      <= 1'b1;
            end
          end else begin
            acc     <= sum[ACC_W-1:0];
            phase_q <= phase_next;
            valid_q <= 1'b1;
            wrap_q  <= carry;
`ifdef PHASE_SWEEP_EN
            if (state == SWEEP) begin
              if (bus.freq_load) begin
                // An explicit load aborts the sweep without a done pulse.
                ftw_active <= bus.freq_word;
                pend_flag  <= 1'b0;
                ack_q      <= 1'b1;
                state      <= RUN;
              end else if (carry) begin
                if (swp_hit) begin
                  ftw_active   <= bus.sweep_stop;
                  sweep_done_q <= 1'b1;
                  state        <= RUN;
                end else begin
                  ftw_active <= swp_sum[ACC_W-1:0];
                end
              end
            end else begin
`endif
              if (pend_apply) begin
                ftw_active <= ftw_pend;
                pend_flag  <= 1'b0;
                ack_q      <= 1'b1;
              end
              // Later assignments win: a deferred load arriving on an apply
              // edge re-arms pend_flag; an immediate load overrides the apply.
              if (bus.freq_load) begin
                if (bus.upd_mode) begin
                  ftw_pend  <= bus.freq_word;
                  pend_flag <= 1'b1;
                end else begin
                  ftw_active <= bus.freq_word;
                  pend_flag  <= 1'b0;
                  ack_q      <= 1'b1;
                end
              end
`ifdef PHASE_SWEEP_EN
              if (bus.sweep_start && !bus.freq_load) state <= SWEEP;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb_dds_phase_acc: directed tests for dds_phase_acc at ACC_W=24, PHASE_W=8.
// Inputs change 1ns after a rising edge; outputs are read at the same point,
// so every read reflects the edge just taken.
module tb_dds_phase_acc;
  localparam int ACC_W   = 24;
  localparam int PHASE_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dds_phase_acc_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) bus ();
  dds_phase_acc #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ACC_W-1:0] w, input logic mode);
    bus.freq_word = w;
    bus.upd_mode  = mode;
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
  endtask

  // Reset in the middle of a run clears outputs and the active FTW.
  task automatic test_reset();
    load_word(24'h010000, 1'b0);
    checks++;
    if (bus.load_ack !== 1'b1) begin
      errors++; $display("FAIL reset_idle_ack: got %b want 1", bus.load_ack);
    end
    bus.en = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.phase_out !== 8'h03) begin
      errors++; $display("FAIL reset_prerun_phase: got %h want 03", bus.phase_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack} !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL reset_outputs: got %h/%b%b%b want 00/000",
                         bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack} !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL reset_first_run: got %h/%b%b%b want 00/110",
                         bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack);
    end
    repeat (4) tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap} !== {8'h00, 2'b10}) begin
      errors++; $display("FAIL reset_ftw_cleared: got %h/%b%b want 00/10",
                         bus.phase_out, bus.phase_valid, bus.wrap);
    end
    bus.en = 1'b0;
    tick();
  endtask

  // FTW 0x010000 walks the phase 0..255 with a wrap every 256 clocks.
  task automatic test_ramp();
    load_word(24'h010000, 1'b1);
    checks++;
    if ({bus.phase_valid, bus.load_ack} !== 2'b01) begin
      errors++; $display("FAIL ramp_idle_load: got %b%b want 01", bus.phase_valid, bus.load_ack);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack} !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL ramp_start: got %h/%b%b%b want 00/110",
                         bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack);
    end
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] ep;
      logic       ew;
      tick();
      ep = 8'(i);
      ew = (i == 256);
      checks++;
      if ({bus.phase_out, bus.wrap} !== {ep, ew}) begin
        errors++; $display("FAIL ramp_step%0d: got %h/%b want %h/%b", i, bus.phase_out, bus.wrap, ep, ew);
      end
    end
    bus.en = 1'b0;
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack} !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL ramp_stop: got %h/%b%b%b want 00/000",
                         bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack);
    end
  endtask

  // Offset 0x80 with FTW 0x100000: 16-clock period starting at 0x80.
  task automatic test_offset();
    bus.phase_offset = 8'h80;
    load_word(24'h100000, 1'b0);
    bus.en = 1'b1;
    tick();
    checks++;
    if ({bus.phase_out, bus.wrap} !== {8'h80, 1'b1}) begin
      errors++; $display("FAIL offset_start: got %h/%b want 80/1", bus.phase_out, bus.wrap);
    end
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] ep;
      logic       ew;
      tick();
      ep = 8'(128 + i * 16);
      ew = (i == 16);
      checks++;
      if ({bus.phase_out, bus.wrap} !== {ep, ew}) begin
        errors++; $display("FAIL offset_step%0d: got %h/%b want %h/%b", i, bus.phase_out, bus.wrap, ep, ew);
      end
    end
    bus.en = 1'b0;
    tick();
    bus.phase_offset = 8'h00;
  endtask

  // Deferred load at phase 0x30 takes effect exactly on the wrap edge.
  task automatic test_wrap_update();
    load_word(24'h100000, 1'b0);
    bus.en = 1'b1;
    tick();
    repeat (3) tick();
    checks++;
    if (bus.phase_out !== 8'h30) begin
      errors++; $display("FAIL wrapupd_setup: got %h want 30", bus.phase_out);
    end
    load_word(24'h200000, 1'b1);
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'h40, 2'b00}) begin
      errors++; $display("FAIL wrapupd_load: got %h/%b%b want 40/00", bus.phase_out, bus.wrap, bus.load_ack);
    end
    for (int i = 1; i <= 12; i++) begin
      logic [7:0] ep;
      logic [1:0] ef;
      tick();
      ep = (i < 12) ? 8'(64 + i * 16) : 8'h00;
      ef = (i < 12) ? 2'b00 : 2'b11;
      checks++;
      if ({bus.phase_out, bus.wrap, bus.load_ack} !== {ep, ef}) begin
        errors++; $display("FAIL wrapupd_step%0d: got %h/%b%b want %h/%b",
                           i, bus.phase_out, bus.wrap, bus.load_ack, ep, ef);
      end
    end
    tick();
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'h20, 2'b00}) begin
      errors++; $display("FAIL wrapupd_after1: got %h/%b%b want 20/00", bus.phase_out, bus.wrap, bus.load_ack);
    end
    tick();
    checks++;
    if (bus.phase_out !== 8'h40) begin
      errors++; $display("FAIL wrapupd_after2: got %h want 40", bus.phase_out);
    end
    bus.en = 1'b0;
    tick();
  endtask

  // Immediate load, then two deferred loads where the second overwrites.
  task automatic test_immediate_update();
    load_word(24'h100000, 1'b0);
    bus.en = 1'b1;
    tick();
    repeat (3) tick();
    load_word(24'h200000, 1'b0);
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'h40, 2'b01}) begin
      errors++; $display("FAIL imm_load: got %h/%b%b want 40/01", bus.phase_out, bus.wrap, bus.load_ack);
    end
    tick();
    checks++;
    if ({bus.phase_out, bus.load_ack} !== {8'h60, 1'b0}) begin
      errors++; $display("FAIL imm_step1: got %h/%b want 60/0", bus.phase_out, bus.load_ack);
    end
    tick();
    checks++;
    if (bus.phase_out !== 8'h80) begin
      errors++; $display("FAIL imm_step2: got %h want 80", bus.phase_out);
    end
    load_word(24'h100000, 1'b1);
    load_word(24'h080000, 1'b1);
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'hC0, 2'b00}) begin
      errors++; $display("FAIL pend_hold: got %h/%b%b want c0/00", bus.phase_out, bus.wrap, bus.load_ack);
    end
    tick();
    tick();
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'h00, 2'b11}) begin
      errors++; $display("FAIL pend_apply: got %h/%b%b want 00/11", bus.phase_out, bus.wrap, bus.load_ack);
    end
    tick();
    tick();
    checks++;
    if (bus.phase_out !== 8'h10) begin
      errors++; $display("FAIL pend_overwrite: got %h want 10", bus.phase_out);
    end
    bus.en = 1'b0;
    tick();
  endtask

  // Zero FTW cannot wrap, so a deferred word applies on the next edge.
  task automatic test_zero_ftw();
    load_word(24'h000000, 1'b0);
    bus.en = 1'b1;
    tick();
    tick();
    load_word(24'h100000, 1'b1);
    tick();
    checks++;
    if ({bus.phase_out, bus.wrap, bus.load_ack} !== {8'h00, 2'b01}) begin
      errors++; $display("FAIL zero_apply: got %h/%b%b want 00/01", bus.phase_out, bus.wrap, bus.load_ack);
    end
    tick();
    checks++;
    if (bus.phase_out !== 8'h10) begin
      errors++; $display("FAIL zero_step: got %h want 10", bus.phase_out);
    end
  endtask

  // Dropping en with a pending word activates it on the same edge.
  task automatic test_en_drop();
    load_word(24'h200000, 1'b1);
    bus.en = 1'b0;
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack} !== {8'h00, 3'b001}) begin
      errors++; $display("FAIL endrop_idle: got %h/%b%b%b want 00/001",
                         bus.phase_out, bus.phase_valid, bus.wrap, bus.load_ack);
    end
    bus.en = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.phase_out, bus.phase_valid} !== {8'h20, 1'b1}) begin
      errors++; $display("FAIL endrop_newftw: got %h/%b want 20/1", bus.phase_out, bus.phase_valid);
    end
    bus.en = 1'b0;
    tick();
  endtask

`ifdef PHASE_SWEEP_EN
  // Sweep 1 -> 4 (x0x10000): three wraps, a single done, then holds at 4.
  task automatic test_sweep();
    int wraps = 0;
    int dones = 0;
    logic [7:0] prev;
    logic [7:0] delta;
    load_word(24'h010000, 1'b0);
    bus.en = 1'b1;
    tick();
    bus.sweep_step  = 24'h010000;
    bus.sweep_stop  = 24'h040000;
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    for (int i = 0; i < 1000 && dones == 0; i++) begin
      tick();
      if (bus.wrap) wraps++;
      if (bus.sweep_done) dones++;
    end
    checks++;
    if ({dones, wraps} !== {32'd1, 32'd3}) begin
      errors++; $display("FAIL sweep_done: got done=%0d wraps=%0d want 1/3", dones, wraps);
    end
    repeat (100) begin
      tick();
      if (bus.sweep_done) dones++;
    end
    prev = bus.phase_out;
    tick();
    delta = bus.phase_out - prev;
    checks++;
    if ({delta, dones} !== {8'h04, 32'd1}) begin
      errors++; $display("FAIL sweep_hold: got step=%h done=%0d want 04/1", delta, dones);
    end
    bus.en = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst              = 1'b1;
    bus.en           = 1'b0;
    bus.freq_word    = '0;
    bus.freq_load    = 1'b0;
    bus.upd_mode     = 1'b0;
    bus.phase_offset = '0;
`ifdef PHASE_SWEEP_EN
    bus.sweep_start  = 1'b0;
    bus.sweep_step   = '0;
    bus.sweep_stop   = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_ramp();
    test_offset();
    test_wrap_update();
    test_immediate_update();
    test_zero_ftw();
    test_en_drop();
`ifdef PHASE_SWEEP_EN
    test_sweep();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
